// File: rtl/openram_port_arbiter.sv
// Round-robin arbiter that lets two requesters share port 0 of one OpenRAM macro.
// One transaction at a time: IDLE grant -> ISSUE (csb low) -> WAIT (reads only) -> ACK pulse.
module openram_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [DATA_W/8-1:0]   a_wmask,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W-1:0]     a_wdata,
    output logic                  a_ack,
    output logic [DATA_W-1:0]     a_rdata,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [DATA_W/8-1:0]   b_wmask,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [DATA_W-1:0]     b_wdata,
    output logic                  b_ack,
    output logic [DATA_W-1:0]     b_rdata,

    output logic                  ram_clk0,
    output logic                  ram_csb0,
    output logic                  ram_web0,
    output logic [DATA_W/8-1:0]   ram_wmask0,
    output logic [ADDR_W-1:0]     ram_addr0,
    output logic [DATA_W-1:0]     ram_din0,
    input  logic [DATA_W-1:0]     ram_dout0
);

    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t              state_q;
    logic                rr_q;        // 1: client B wins the next tie
    logic                gnt_b_q;
    logic                we_q;
    logic [1:0]          wait_cnt_q;

    logic                gnt_b_d;
    logic                sel_we_d;
    logic [MASK_W-1:0]   sel_wmask_d;
    logic [ADDR_W-1:0]   sel_addr_d;
    logic [DATA_W-1:0]   sel_wdata_d;
    logic [MASK_W-1:0]   issue_wmask_d;

    assign ram_clk0 = wb_clk_i;

    always_comb begin
        gnt_b_d     = b_req & (~a_req | rr_q);
        sel_we_d    = gnt_b_d ? b_we    : a_we;
        sel_wmask_d = gnt_b_d ? b_wmask : a_wmask;
        sel_addr_d  = gnt_b_d ? b_addr  : a_addr;
        sel_wdata_d = gnt_b_d ? b_wdata : a_wdata;
    end

    // Reads never present a write mask to the macro.
    generate
        for (genvar gi = 0; gi < MASK_W; gi++) begin : g_issue_mask
            assign issue_wmask_d[gi] = sel_we_d & sel_wmask_d[gi];
        end
    endgenerate

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            gnt_b_q    <= 1'b0;
            we_q       <= 1'b0;
            wait_cnt_q <= '0;
            ram_csb0   <= 1'b1;
            ram_web0   <= 1'b1;
            ram_wmask0 <= '0;
            ram_addr0  <= '0;
            ram_din0   <= '0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (a_req || b_req) begin
                        gnt_b_q    <= gnt_b_d;
                        rr_q       <= ~gnt_b_d;
                        we_q       <= sel_we_d;
                        ram_csb0   <= 1'b0;
                        ram_web0   <= ~sel_we_d;
                        ram_wmask0 <= issue_wmask_d;
                        ram_addr0  <= sel_addr_d;
                        ram_din0   <= sel_wdata_d;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_csb0 <= 1'b1;
                    ram_web0 <= 1'b1;
                    if (we_q) begin
                        a_ack   <= ~gnt_b_q;
                        b_ack   <= gnt_b_q;
                        state_q <= ACK;
                    end else begin
                        wait_cnt_q <= 2'(RD_LATENCY - 1);
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt_q == 2'd0) begin
                        if (gnt_b_q) begin
                            b_rdata <= ram_dout0;
                        end else begin
                            a_rdata <= ram_dout0;
                        end
                        a_ack   <= ~gnt_b_q;
                        b_ack   <= gnt_b_q;
                        state_q <= ACK;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 2'd1;
                    end
                end
                ACK: begin
                    a_ack   <= 1'b0;
                    b_ack   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
